cond_issue_ctrl: RTL and testbench

//  Consumer side of the NZCV status flags. Sits between ID and EXE.

---
 rtl/cond_pkg.sv | 38 +++
 rtl/cond_issue_ctrl_if.sv | 27 ++
 rtl/arm_cond_eval.sv | 40 ++++
 rtl/cond_issue_ctrl.sv | 95 +++++++++
 tb/tb_cond_issue_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cond_pkg.sv
// Shared definitions for ARM condition-code handling: condition encodings,
// NZCV bit positions and the EXE slot record used by the issue controller.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic valid;
    logic exec;
    logic s;
  } ex_slot_t;

  // AL and NV resolve without looking at the flags, so they never wait on them.
  function automatic logic is_uncond(input logic [3:0] cond);
    return (cond == COND_AL) || (cond == COND_NV);
  endfunction

endpackage

// File: rtl/cond_issue_ctrl_if.sv
// ID / writeback / EXE signal bundle of the conditional issue controller.
interface cond_issue_ctrl_if;

  logic       id_valid;
  logic [3:0] id_cond;
  logic       id_s;
  logic       id_ready;
  logic       wb_s;
  logic [3:0] wb_stat_bits;
  logic       flush;
  logic       ex_valid;
  logic       ex_exec;
  logic       ex_s;
  logic [3:0] flags;
  logic       err_underflow;

  modport master (
    output id_valid, id_cond, id_s, wb_s, wb_stat_bits, flush,
    input  id_ready, ex_valid, ex_exec, ex_s, flags, err_underflow
  );

  modport slave (
    input  id_valid, id_cond, id_s, wb_s, wb_stat_bits, flush,
    output id_ready, ex_valid, ex_exec, ex_s, flags, err_underflow
  );

endinterface

// File: rtl/arm_cond_eval.sv
// Pure combinational ARM condition evaluator: does cond pass for the given NZCV?
module arm_cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_issue_ctrl.sv
// Issues ID instructions into EXE with an execute/annul bit, holding ID back
// while the flags it depends on are still owed by in-flight flag setters.
module cond_issue_ctrl
  import cond_pkg::*;
#(
  parameter int MAX_PEND = 3,
  parameter int FWD      = 1
)
(
  input logic         clk,
  input logic         rst_n,
  cond_issue_ctrl_if.slave bus
);

  localparam int PW = $clog2(MAX_PEND + 1);
  localparam int SW = PW + 2;
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);
  localparam logic [PW-1:0] PEND_ONE = PW'(1);
  localparam logic [SW-1:0] PEND_MAX_W = SW'(MAX_PEND);

  logic [PW-1:0] pending;
  logic [PW-1:0] pend_next;
  logic [3:0]    flags_q;
  logic          err_q;
  ex_slot_t      ex_q;

  logic          bypass;
  logic          fresh;
  logic [3:0]    eff;
  logic          pass;
  logic          stall_flags;
  logic          stall_full;
  logic          ready;
  logic          accept;
  logic          inc;
  logic          kill;
  logic [SW-1:0] up;
  logic [SW-1:0] down;
  logic [SW-1:0] diff;

  // The last outstanding setter writing back this cycle makes its flags usable immediately.
  assign bypass = (FWD != 0) && bus.wb_s && (pending == PEND_ONE);
  assign fresh  = (pending == '0) || bypass;
  assign eff    = bypass ? bus.wb_stat_bits : flags_q;

  arm_cond_eval u_eval (
    .cond (bus.id_cond),
    .nzcv (eff),
    .pass (pass)
  );

  assign stall_flags = bus.id_valid && !is_uncond(bus.id_cond) && !fresh;
  assign stall_full  = bus.id_valid && bus.id_s && (pending == PEND_MAX) && !bus.wb_s;
  assign ready       = !(stall_flags || stall_full);
  assign accept      = bus.id_valid && ready;
  assign inc         = accept && bus.id_s && pass;
  assign kill        = bus.flush && ex_q.valid && ex_q.s;

  // All same-cycle pending events are netted first, then clamped to 0..MAX_PEND.
  always_comb begin
    up        = SW'(pending) + SW'(inc);
    down      = SW'(bus.wb_s) + SW'(kill);
    diff      = '0;
    pend_next = '0;
    if (up > down) begin
      diff = up - down;
      if (diff > PEND_MAX_W) pend_next = PEND_MAX;
      else                   pend_next = diff[PW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
      ex_q    <= '0;
    end else begin
      pending <= pend_next;
      if (bus.wb_s) flags_q <= bus.wb_stat_bits;
      if (bus.wb_s && (pending == '0)) err_q <= 1'b1;
      ex_q.valid <= accept && !bus.flush;
      ex_q.exec  <= accept && !bus.flush && pass;
      ex_q.s     <= accept && !bus.flush && pass && bus.id_s;
    end
  end

  assign bus.id_ready      = ready;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_exec       = ex_q.exec;
  assign bus.ex_s          = ex_q.s;
  assign bus.flags         = flags_q;
  assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Self-checking bench: drives a FWD=0 and a FWD=1 instance with identical stimulus
// and checks both against directed vectors and a flag/pending reference model.
module tb_cond_issue_ctrl;
  import cond_pkg::*;

  localparam int MAXP = 3;

  typedef struct {
    logic       v;
    logic [3:0] c;
    logic       s;
    logic       w;
    logic [3:0] b;
    logic       f;
    logic [1:0] rdy;
    logic [1:0] exv;
    logic [1:0] exe;
    logic [1:0] exs;
    logic [3:0] flg;
    logic [1:0] err;
  } vec_t;

  logic clk;
  logic rst_n;
  logic       drv_v, drv_s, drv_w, drv_f;
  logic [3:0] drv_c, drv_b;

  int checks;
  int errors;

  logic [1:0] got_rdy;
  logic [1:0] exp_rdy;

  int         m_pend [2];
  logic [3:0] m_flags[2];
  logic       m_exv  [2];
  logic       m_exe  [2];
  logic       m_exs  [2];
  logic       m_err  [2];

  vec_t tbl[$];

  cond_issue_ctrl_if bus0 ();
  cond_issue_ctrl_if bus1 ();

  assign bus0.id_valid     = drv_v;
  assign bus0.id_cond      = drv_c;
  assign bus0.id_s         = drv_s;
  assign bus0.wb_s         = drv_w;
  assign bus0.wb_stat_bits = drv_b;
  assign bus0.flush        = drv_f;
  assign bus1.id_valid     = drv_v;
  assign bus1.id_cond      = drv_c;
  assign bus1.id_s         = drv_s;
  assign bus1.wb_s         = drv_w;
  assign bus1.wb_stat_bits = drv_b;
  assign bus1.flush        = drv_f;

  cond_issue_ctrl #(.MAX_PEND(MAXP), .FWD(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  cond_issue_ctrl #(.MAX_PEND(MAXP), .FWD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Architectural meaning of the condition: even codes test a predicate, odd codes its inverse.
  function automatic logic cond_ok(input logic [3:0] cd, input logic [3:0] f);
    logic n, z, cf, v, r;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (cd[3:1])
      3'd0:    r = z;
      3'd1:    r = cf;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = cf && !z;
      3'd5:    r = (n == v);
      3'd6:    r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (cd[3:1] == 3'd7) return !cd[0];
    return cd[0] ? !r : r;
  endfunction

  function automatic logic model_bypass(input int k);
    return (k == 1) && drv_w && (m_pend[k] == 1);
  endfunction

  function automatic logic model_ready(input int k);
    if (!drv_v) return 1'b1;
    if (drv_s && (m_pend[k] == MAXP) && !drv_w) return 1'b0;
    if (drv_c[3:1] == 3'd7) return 1'b1;
    return (m_pend[k] == 0) || model_bypass(k);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0; m_flags[k] = 4'h0;
      m_exv[k] = 1'b0; m_exe[k] = 1'b0; m_exs[k] = 1'b0; m_err[k] = 1'b0;
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [3:0] c, input logic s,
                                input logic w, input logic [3:0] b, input logic f);
    logic       acc [2];
    logic       p   [2];
    int         np  [2];
    @(negedge clk);
    drv_v = v; drv_c = c; drv_s = s; drv_w = w; drv_b = b; drv_f = f;
    #1;
    got_rdy = {bus1.id_ready, bus0.id_ready};
    for (int k = 0; k < 2; k++) begin
      exp_rdy[k] = model_ready(k);
      acc[k] = drv_v && exp_rdy[k];
      p[k]   = cond_ok(drv_c, model_bypass(k) ? drv_b : m_flags[k]);
      np[k]  = m_pend[k] + ((acc[k] && drv_s && p[k]) ? 1 : 0) - (drv_w ? 1 : 0)
               - ((drv_f && m_exv[k] && m_exs[k]) ? 1 : 0);
      if (np[k] < 0) np[k] = 0;
      if (np[k] > MAXP) np[k] = MAXP;
    end
    check_output("model_id_ready", 8'(got_rdy), 8'(exp_rdy));
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (drv_w && m_pend[k] == 0) m_err[k] = 1'b1;
      if (drv_w) m_flags[k] = drv_b;
      m_pend[k] = np[k];
      m_exv[k]  = acc[k] && !drv_f;
      m_exe[k]  = m_exv[k] && p[k];
      m_exs[k]  = m_exe[k] && drv_s;
    end
    #1;
    check_output("model_ex_valid", 8'({bus1.ex_valid, bus0.ex_valid}), 8'({m_exv[1], m_exv[0]}));
    check_output("model_ex_exec", 8'({bus1.ex_exec, bus0.ex_exec}), 8'({m_exe[1], m_exe[0]}));
    check_output("model_ex_s", 8'({bus1.ex_s, bus0.ex_s}), 8'({m_exs[1], m_exs[0]}));
    check_output("model_err", 8'({bus1.err_underflow, bus0.err_underflow}), 8'({m_err[1], m_err[0]}));
    check_output("model_flags0", 8'(bus0.flags), 8'(m_flags[0]));
    check_output("model_flags1", 8'(bus1.flags), 8'(m_flags[1]));
  endtask

  function automatic vec_t mk(input logic v, input logic [3:0] c, input logic s, input logic w,
                              input logic [3:0] b, input logic f, input logic [1:0] rdy,
                              input logic [1:0] exv, input logic [1:0] exe, input logic [1:0] exs,
                              input logic [3:0] flg, input logic [1:0] err);
    vec_t r;
    r.v = v; r.c = c; r.s = s; r.w = w; r.b = b; r.f = f;
    r.rdy = rdy; r.exv = exv; r.exe = exe; r.exs = exs; r.flg = flg; r.err = err;
    return r;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drv_v = 0; drv_c = 0; drv_s = 0; drv_w = 0; drv_b = 0; drv_f = 0;
    model_reset();

    // Bit 1 of each 2-bit expectation is the FWD=1 instance, bit 0 the FWD=0 instance.
    //              v  cond     s  w  bits     f  rdy    exv    exe    exs    flags    err
    tbl.push_back(mk(1, COND_EQ, 0, 0, 4'b0000, 0, 2'b11, 2'b11, 2'b00, 2'b00, 4'b0000, 2'b00));
    tbl.push_back(mk(1, COND_AL, 1, 0, 4'b0000, 0, 2'b11, 2'b11, 2'b11, 2'b11, 4'b0000, 2'b00));
    tbl.push_back(mk(1, COND_NE, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00));
    tbl.push_back(mk(1, COND_NE, 0, 1, 4'b0100, 0, 2'b10, 2'b10, 2'b00, 2'b00, 4'b0100, 2'b00));
    tbl.push_back(mk(1, COND_NE, 0, 0, 4'b0000, 0, 2'b11, 2'b11, 2'b00, 2'b00, 4'b0100, 2'b00));
    tbl.push_back(mk(1, COND_EQ, 1, 0, 4'b0000, 0, 2'b11, 2'b11, 2'b11, 2'b11, 4'b0100, 2'b00));
    tbl.push_back(mk(1, COND_AL, 1, 0, 4'b0000, 1, 2'b11, 2'b00, 2'b00, 2'b00, 4'b0100, 2'b00));
    tbl.push_back(mk(1, COND_AL, 1, 0, 4'b0000, 0, 2'b11, 2'b11, 2'b11, 2'b11, 4'b0100, 2'b00));
    tbl.push_back(mk(1, COND_AL, 1, 0, 4'b0000, 0, 2'b11, 2'b11, 2'b11, 2'b11, 4'b0100, 2'b00));
    tbl.push_back(mk(1, COND_AL, 1, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0100, 2'b00));
    tbl.push_back(mk(1, COND_AL, 1, 1, 4'b1001, 0, 2'b11, 2'b11, 2'b11, 2'b11, 4'b1001, 2'b00));
    tbl.push_back(mk(0, COND_EQ, 0, 1, 4'b1001, 0, 2'b11, 2'b00, 2'b00, 2'b00, 4'b1001, 2'b00));
    tbl.push_back(mk(1, COND_GE, 0, 1, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00));
    tbl.push_back(mk(1, COND_GE, 0, 1, 4'b1001, 0, 2'b10, 2'b10, 2'b10, 2'b00, 4'b1001, 2'b00));
    tbl.push_back(mk(1, COND_NV, 1, 1, 4'b0010, 0, 2'b11, 2'b11, 2'b00, 2'b00, 4'b0010, 2'b11));
    tbl.push_back(mk(1, COND_HI, 0, 0, 4'b0000, 0, 2'b11, 2'b11, 2'b11, 2'b00, 4'b0010, 2'b11));
    tbl.push_back(mk(1, COND_LE, 1, 0, 4'b0000, 0, 2'b11, 2'b11, 2'b00, 2'b00, 4'b0010, 2'b11));

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_ex_valid", 8'({bus1.ex_valid, bus0.ex_valid}), 8'h00);
    check_output("reset_flags", 8'({bus1.flags, bus0.flags}), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply_stimulus(tbl[i].v, tbl[i].c, tbl[i].s, tbl[i].w, tbl[i].b, tbl[i].f);
      check_output($sformatf("tbl%0d_ready", i), 8'(got_rdy), 8'(tbl[i].rdy));
      check_output($sformatf("tbl%0d_ex_valid", i), 8'({bus1.ex_valid, bus0.ex_valid}), 8'(tbl[i].exv));
      check_output($sformatf("tbl%0d_ex_exec", i), 8'({bus1.ex_exec, bus0.ex_exec}), 8'(tbl[i].exe));
      check_output($sformatf("tbl%0d_ex_s", i), 8'({bus1.ex_s, bus0.ex_s}), 8'(tbl[i].exs));
      check_output($sformatf("tbl%0d_flags0", i), 8'(bus0.flags), 8'(tbl[i].flg));
      check_output($sformatf("tbl%0d_flags1", i), 8'(bus1.flags), 8'(tbl[i].flg));
      check_output($sformatf("tbl%0d_err", i), 8'({bus1.err_underflow, bus0.err_underflow}), 8'(tbl[i].err));
    end

    // Build up two outstanding setters, then reset mid-stream.
    apply_stimulus(1, COND_AL, 1, 0, 4'h0, 0);
    apply_stimulus(1, COND_AL, 1, 0, 4'h0, 0);
    @(negedge clk);
    drv_v = 0; drv_s = 0; drv_w = 0; drv_f = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output("rst_ex_valid", 8'({bus1.ex_valid, bus0.ex_valid}), 8'h00);
    check_output("rst_ex_exec", 8'({bus1.ex_exec, bus0.ex_exec}), 8'h00);
    check_output("rst_ex_s", 8'({bus1.ex_s, bus0.ex_s}), 8'h00);
    check_output("rst_err", 8'({bus1.err_underflow, bus0.err_underflow}), 8'h00);
    check_output("rst_flags", 8'({bus1.flags, bus0.flags}), 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply_stimulus(1, COND_EQ, 0, 0, 4'h0, 0);
    check_output("rst_release_ready", 8'(got_rdy), 8'h03);
    check_output("rst_release_exec", 8'({bus1.ex_exec, bus0.ex_exec}), 8'h00);

    for (int i = 0; i < 800; i++) begin
      apply_stimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 1'($urandom),
                     $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
